// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU execute stage: operation
//               encodings, FSM state type, default datapath width and the
//               signed add/sub overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default datapath width for the execute stage and its multiplier
    localparam int c_WIDTH_DEFAULT = 32;

    // alu_op encodings; codes 9..15 are unused and produce a zero result
    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR  = 4'd5;
    localparam logic [3:0] c_OP_SLT  = 4'd6;
    localparam logic [3:0] c_OP_SRL  = 4'd7;
    localparam logic [3:0] c_OP_MULU = 4'd8;

    // Execute-stage control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    // Two's-complement overflow: both addend signs agree and the sum sign
    // differs from them. For subtraction pass the inverted sign of b.
    function automatic logic add_overflow(input logic i_sign_a,
                                          input logic i_sign_b,
                                          input logic i_sign_r);
        return (i_sign_a == i_sign_b) && (i_sign_r != i_sign_a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mul
// Description : Iterative unsigned shift-add multiplier producing the low
//               WIDTH bits of i_a*i_b. One multiplier bit is consumed per
//               cycle; after i_start the unit runs WIDTH iterations and
//               pulses o_done during the final one, with o_product carrying
//               the finished value in that same cycle. i_abort discards any
//               operation in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;   // multiplicand, shifted left each iteration
    logic [WIDTH-1:0] r_mplier;  // multiplier, shifted right each iteration
    logic [WIDTH-1:0] r_acc;     // partial-product accumulator

    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_acc_next;

    assign w_partial  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_partial;

    // The last iteration's sum is exposed directly so the caller can
    // register the product on the same edge that finishes the multiply.
    assign o_done    = r_busy && (r_cnt == c_LAST_ITER);
    assign o_product = w_acc_next;

    // Operand load on start, one shift-add step per cycle while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_abort) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ex_stage
// Description : Pipeline execute stage. Accepts an operand bundle with a
//               valid/ready handshake, computes the selected ALU operation
//               and holds the registered result until EX/MEM takes it.
//               Single-cycle ops have one cycle of latency and can issue
//               back-to-back; flush drops held or in-flight work.
//               Optional feature macro: ALU_EX_MULU_EN enables the iterative
//               unsigned multiply (op 8, WIDTH-cycle latency). Without it
//               op 8 behaves like any unused code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    alu_state_t       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A new bundle is taken when idle, or when the held result leaves on
    // this same edge. Reset and flush block acceptance outright.
    assign w_in_ready = rst_n && !flush &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_HOLD) && out_ready));
    assign w_accept   = in_valid && w_in_ready;

`ifdef ALU_EX_MULU_EN
    assign w_is_mul = (alu_op == c_OP_MULU);
`else
    assign w_is_mul = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_lt   = $signed(a) < $signed(b);

    // Operation select; unused codes (and op 8 without the multiplier)
    // fall through to zero result and no overflow
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (alu_op)
            c_OP_AND: w_alu_res = a & b;
            c_OP_OR:  w_alu_res = a | b;
            c_OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = add_overflow(a[WIDTH-1], b[WIDTH-1], w_sum[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = add_overflow(a[WIDTH-1], ~b[WIDTH-1], w_diff[WIDTH-1]);
            end
            c_OP_XOR: w_alu_res = a ^ b;
            c_OP_NOR: w_alu_res = ~(a | b);
            c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_SRL: w_alu_res = a >> b[4:0];
            default:  w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
`ifdef ALU_EX_MULU_EN
    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_mul_start = w_accept && w_is_mul;

    alu_seq_mul #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_abort   (flush),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered result, flags and out_valid
    // ------------------------------------------------------------------
    // Flush outranks everything but reset; acceptance of a new bundle
    // outranks the per-state bookkeeping because it also covers the
    // HOLD back-to-back case where the old result leaves on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state     <= ST_MUL;
                r_out_valid <= 1'b0;
                r_zero      <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                r_state     <= ST_HOLD;
                r_out_valid <= 1'b1;
                r_result    <= w_alu_res;
                r_zero      <= (w_alu_res == '0);
                r_overflow  <= w_alu_ovf;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                end
`ifdef ALU_EX_MULU_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_product;
                        r_zero      <= (w_mul_product == '0);
                        r_overflow  <= 1'b0;
                    end
                end
`endif
                ST_HOLD: begin
                    // out_ready with no new bundle: result consumed, go idle
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_zero      <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_zero      <= 1'b0;
                    r_overflow  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Flags are only meaningful alongside a valid result
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero && r_out_valid;
    assign overflow  = r_overflow && r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ex_stage
// Description : Self-checking bench for alu_ex_stage. Stimulus pushes the
//               reference result into a queue on acceptance; a monitor pops
//               and compares whenever a result leaves the stage.
//               Honours ALU_EX_MULU_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ex_stage;

    localparam int W   = 32;
    localparam int TMO = 300;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    exp_t q[$];

    alu_ex_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: arithmetic straight from the operation definitions
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.res = '0;
        e.ov  = 1'b0;
        case (op)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin
                s = sx + sy;
                e.res = s[31:0];
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                s = sx - sy;
                e.res = s[31:0];
                e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: e.res = x ^ y;
            4'd5: e.res = ~(x | y);
            4'd6: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd7: e.res = x >> y[4:0];
`ifdef ALU_EX_MULU_EN
            4'd8: begin
                p = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
            end
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Offer one bundle starting at a negedge; returns at the negedge after
    // the accepting edge. waited = cycles spent waiting for in_ready.
    task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        waited   = 0;
        #1;
        while (!in_ready && waited < TMO) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            q.push_back(model(op, x, y));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Randomised EX/MEM backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares departing results, held-result stability and flag gating
    initial begin
        bit           held = 1'b0;
        logic [W-1:0] held_res = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && !flush) begin
                if (!out_valid) chk("flags_gated", {30'd0, zero, overflow}, '0);
                if (held) begin
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("hold_result", result, held_res);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: result %h with empty scoreboard", result);
                    end else begin
                        e = q.pop_front();
                        chk("sb_result", result, e.res);
                        chk("sb_flags", {30'd0, zero, overflow}, {30'd0, e.z, e.ov});
                    end
                end
                held     = out_valid && !out_ready;
                held_res = result;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int t;
        bit seen;

        // Reset held low for two edges
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_flags", {30'd0, zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed single-cycle ops, back-to-back with out_ready high
        out_ready = 1'b1;
        send(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, w);
        #1;
        chk("and_result", result, 32'hF000_F000);
        chk("and_zero", {31'd0, zero}, 32'd0);
        send(4'd3, 32'd5, 32'd5, w);
        #1;
        chk("sub_result", result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        send(4'd2, 32'h7FFF_FFFF, 32'd1, w);
        #1;
        chk("add_result", result, 32'h8000_0000);
        chk("add_ovf", {31'd0, overflow}, 32'd1);
        send(4'd6, 32'hFFFF_FFFF, 32'd1, w);
        #1;
        chk("slt_result", result, 32'd1);
        @(negedge clk);

        // Backpressure: result held three cycles, then out and in on one edge
        out_ready = 1'b0;
        send(4'd2, 32'd1, 32'd2, w);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(4'd4, 32'h0000_00FF, 32'h0000_000F, w);
        chk("b2b_no_wait", w, 0);
        #1;
        chk("b2b_result", result, 32'h0000_00F0);
        @(negedge clk);

        // Flush drops a held result and refuses a bundle offered alongside
        out_ready = 1'b0;
        send(4'd1, 32'h1234_0000, 32'h0000_5678, w);
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_op   = 4'd0;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);

`ifdef ALU_EX_MULU_EN
        // Multiply: WIDTH busy cycles, then the product
        send(4'd8, 32'h0001_0001, 32'd3, w);
        seen = 1'b0;
        for (int i = 0; i < W; i++) begin
            #1;
            if (in_ready || out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("mul_busy", {31'd0, seen}, 32'd0);
        #1;
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_result", result, 32'h0003_0003);
        @(negedge clk);

        // Flush ten cycles into a multiply: no result ever appears
        send(4'd8, 32'h0001_0001, 32'd3, w);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        q.delete();
        @(negedge clk);
        flush = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            #1;
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("mul_flush_no_valid", {31'd0, seen}, 32'd0);
        chk("mul_flush_ready", {31'd0, in_ready}, 32'd1);
`else
        // Op 8 without the multiplier: zero result after one cycle
        send(4'd8, 32'h0001_0001, 32'd3, w);
        #1;
        chk("op8_valid", {31'd0, out_valid}, 32'd1);
        chk("op8_result", result, 32'd0);
        @(negedge clk);
`endif

        // Random phase with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), w);
        end

        t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
